// File: rtl/m_conv_seq.sv
// Run controller for one conv layer engine: clears the engine, streams the input map
// from input RAM, keeps the engine enabled and stores every saved result in output RAM.
module m_conv_seq #(
   parameter int NUM_IN    = 9216,
   parameter int NUM_OUT   = 7744,
   parameter int RD_LAT    = 1,
   parameter int DRAIN_MAX = 2048
) (
   input  logic               clk_in,
   input  logic               rst_n,
   input  logic               go,
   input  logic               abort,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic               rd_en,
   output logic [13:0]        rd_addr,
   input  logic signed [15:0] rd_data,
   output logic               eng_clr,
   output logic               eng_start,
   output logic signed [15:0] eng_map_in,
   input  logic signed [15:0] eng_map_out,
   input  logic               eng_save,
   input  logic               eng_ready,
   output logic               wr_en,
   output logic [12:0]        wr_addr,
   output logic [15:0]        wr_data
);

   localparam int DW = $clog2(DRAIN_MAX) + 1;
   localparam logic [13:0]   RD_LAST    = 14'(NUM_IN - 1);
   localparam logic [13:0]   OUT_END    = 14'(NUM_OUT);
   localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_MAX - 1);

   typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_FEED, S_DRAIN, S_DONE} state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic                r_clr_cnt;
   logic [13:0]         r_rd_addr;
   logic [13:0]         r_out_cnt;
   logic [DW-1:0]       r_drain_cnt;
   logic                r_started;
   logic signed [15:0]  r_map_in;
   logic                r_wr_en;
   logic [12:0]         r_wr_addr;
   logic [15:0]         r_wr_data;
   logic                r_err;
   logic [RD_LAT:0]     w_vld_chain;
   logic                w_feeding;
   logic                w_keep;
   logic                w_go;
   logic                w_capture;
   logic                w_extra;
   logic                w_timeout;
   logic                w_unused_ready;

   // eng_ready is informational only; the result count decides completion.
   assign w_unused_ready = eng_ready;

   assign w_feeding = (r_state == S_FEED) || (r_state == S_DRAIN);
   assign w_keep    = (w_state_next == S_FEED) || (w_state_next == S_DRAIN);
   assign w_go      = (r_state == S_IDLE) && go && !abort;
   assign w_capture = w_feeding && !abort && eng_save && (r_out_cnt != OUT_END);
   assign w_extra   = w_feeding && !abort && eng_save && (r_out_cnt == OUT_END);
   assign w_timeout = (r_state == S_DRAIN) && !abort && (r_drain_cnt == DRAIN_LAST)
                      && (r_out_cnt != OUT_END);

   always_comb begin
      w_state_next = r_state;
      busy         = 1'b1;
      done         = 1'b0;
      eng_clr      = 1'b0;
      rd_en        = 1'b0;
      case (r_state)
         S_IDLE: begin
            busy    = 1'b0;
            eng_clr = 1'b1;
            if (go && !abort) w_state_next = S_CLEAR;
         end
         S_CLEAR: begin
            eng_clr = 1'b1;
            if (abort)          w_state_next = S_IDLE;
            else if (r_clr_cnt) w_state_next = S_FEED;
         end
         S_FEED: begin
            rd_en = 1'b1;
            if (abort)                     w_state_next = S_IDLE;
            else if (r_rd_addr == RD_LAST) w_state_next = S_DRAIN;
         end
         S_DRAIN: begin
            if (abort) w_state_next = S_IDLE;
            else if ((r_out_cnt == OUT_END) || (r_drain_cnt == DRAIN_LAST))
               w_state_next = S_DONE;
         end
         S_DONE: begin
            done         = 1'b1;
            w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Read-valid pipeline matching the input RAM latency; flushed when the run stops.
   assign w_vld_chain[0] = rd_en;
   generate
      for (genvar gi = 0; gi < RD_LAT; gi++) begin : g_vld
         logic r_vld;
         always_ff @(posedge clk_in) begin
            if (!rst_n) r_vld <= 1'b0;
            else        r_vld <= w_vld_chain[gi] && w_keep;
         end
         assign w_vld_chain[gi+1] = r_vld;
      end
   endgenerate

   always_ff @(posedge clk_in) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_clr_cnt   <= 1'b0;
         r_rd_addr   <= '0;
         r_out_cnt   <= '0;
         r_drain_cnt <= '0;
         r_started   <= 1'b0;
         r_map_in    <= '0;
         r_wr_en     <= 1'b0;
         r_wr_addr   <= '0;
         r_wr_data   <= '0;
         r_err       <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_clr_cnt   <= (r_state == S_CLEAR) ? ~r_clr_cnt : 1'b0;
         r_drain_cnt <= (r_state == S_DRAIN) ? r_drain_cnt + 1'b1 : '0;
         if (w_go)
            r_rd_addr <= '0;
         else if ((r_state == S_FEED) && (r_rd_addr != RD_LAST))
            r_rd_addr <= r_rd_addr + 1'b1;
         // Engine enable rises together with pixel 0 and drops only when the run ends.
         r_map_in <= (w_vld_chain[RD_LAT] && w_keep) ? rd_data : 16'sd0;
         if (!w_keep)                     r_started <= 1'b0;
         else if (w_vld_chain[RD_LAT])    r_started <= 1'b1;
         r_wr_en <= w_capture;
         if (w_capture) begin
            r_wr_addr <= r_out_cnt[12:0];
            r_wr_data <= eng_map_out;
            r_out_cnt <= r_out_cnt + 1'b1;
         end else if (w_go) begin
            r_out_cnt <= '0;
         end
         if (w_go)                       r_err <= 1'b0;
         else if (w_extra || w_timeout)  r_err <= 1'b1;
      end
   end

   assign err        = r_err;
   assign rd_addr    = r_rd_addr;
   assign eng_start  = r_started;
   assign eng_map_in = r_map_in;
   assign wr_en      = r_wr_en;
   assign wr_addr    = r_wr_addr;
   assign wr_data    = r_wr_data;

endmodule
